// File: rtl/burst_pkg.sv
// Shared constants and state type for the AXI burst read/write engines.
package burst_pkg;
   localparam int          BURST_BYTES  = 128;
   localparam int          BEAT_BYTES   = 8;
   localparam int          BURST_SH     = $clog2(BURST_BYTES);
   localparam logic [1:0]  ARSIZE_8B    = 2'b11;
   localparam logic [1:0]  ARBURST_INCR = 2'b01;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} rd_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head word visible on pop_dat one cycle after its push.
// Push while full and pop while empty are ignored; producer/consumer gate on full/empty.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/axi_burst_reader.sv
// DMA read front-end: credit-gated INCR bursts into a FIFO, streamed out as 64-bit words.
// AR one cycle after start, word one cycle after its beat; out_ready stalls withhold AR credit.
module axi_burst_reader
   import burst_pkg::*;
#(
   parameter int BURST_BEATS = 16,
   parameter int FIFO_BURSTS = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [31:0]       len_bytes,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   MAXI0_ARADDR,
   input  logic              MAXI0_ARADDR_ready,
   output logic [3:0]        MAXI0_ARLEN,
   output logic [1:0]        MAXI0_ARSIZE,
   output logic [1:0]        MAXI0_ARBURST,
   input  logic [64:0]       MAXI0_RDATA,
   input  logic [1:0]        MAXI0_RRESP,
   input  logic              MAXI0_RLAST,
   output logic              MAXI0_RDATA_ready,
   output logic [63:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   localparam int DEPTH  = FIFO_BURSTS * BURST_BEATS;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam int AHI_W  = ADDR_W - BURST_SH;
   localparam int NBUR_W = 32 - BURST_SH;
   localparam int WORD_W = NBUR_W + $clog2(BURST_BEATS);

   rd_state_t         state;
   logic [AHI_W-1:0]  addr_hi;
   logic [NBUR_W-1:0] bursts_left;
   logic [WORD_W-1:0] words_left;
   logic [CNT_W-1:0]  outstanding;
   logic [BEAT_W-1:0] beat_cnt;
   logic              ar_vld;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push_vld;
   logic              pop_vld;
   logic              ar_acc;
   logic              last_beat;
   logic              credit_ok;
   logic [CNT_W:0]    committed;
   logic              unused_bits;

   // Beats arriving with nothing outstanding are leftovers of an aborted transfer.
   assign push_vld  = MAXI0_RDATA[64] && (outstanding != '0) && !fifo_full;
   assign pop_vld   = out_valid && out_ready;
   assign ar_acc    = ar_vld && MAXI0_ARADDR_ready;
   assign last_beat = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
   assign committed = {1'b0, fifo_cnt} + {1'b0, outstanding} + (CNT_W+1)'(BURST_BEATS);
   assign credit_ok = (committed <= (CNT_W+1)'(DEPTH));

   assign MAXI0_ARADDR      = {ar_vld, addr_hi, {BURST_SH{1'b0}}};
   assign MAXI0_ARLEN       = 4'(BURST_BEATS - 1);
   assign MAXI0_ARSIZE      = ARSIZE_8B;
   assign MAXI0_ARBURST     = ARBURST_INCR;
   assign MAXI0_RDATA_ready = 1'b1;
   assign out_valid         = !fifo_empty;
   assign unused_bits       = ^{src_addr[BURST_SH-1:0], len_bytes[BURST_SH-1:0]};

   sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .push     (push_vld),
      .push_dat (MAXI0_RDATA[63:0]),
      .pop      (pop_vld),
      .pop_dat  (out_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state       <= IDLE;
         addr_hi     <= '0;
         bursts_left <= '0;
         words_left  <= '0;
         outstanding <= '0;
         beat_cnt    <= '0;
         ar_vld      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done        <= 1'b0;
         outstanding <= outstanding + (ar_acc ? CNT_W'(BURST_BEATS) : CNT_W'(0))
                                    - (push_vld ? CNT_W'(1) : CNT_W'(0));
         if (push_vld) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
            if ((MAXI0_RLAST != last_beat) || (MAXI0_RRESP != 2'b00)) err <= 1'b1;
         end
         if (pop_vld && (words_left != '0)) words_left <= words_left - WORD_W'(1);

         case (state)
            IDLE: begin
               if (start) begin
                  addr_hi     <= src_addr[ADDR_W-1:BURST_SH];
                  bursts_left <= len_bytes[31:BURST_SH];
                  words_left  <= WORD_W'(len_bytes[31:BURST_SH]) << $clog2(BURST_BEATS);
                  beat_cnt    <= '0;
                  err         <= 1'b0;
                  busy        <= 1'b1;
                  ar_vld      <= (len_bytes[31:BURST_SH] != '0) && credit_ok;
                  state       <= (len_bytes[31:BURST_SH] != '0) ? REQ : DRAIN;
               end
            end
            REQ: begin
               // One idle cycle after each accept lets credit see the new outstanding count.
               if (ar_acc) begin
                  ar_vld      <= 1'b0;
                  addr_hi     <= addr_hi + AHI_W'(1);
                  bursts_left <= bursts_left - NBUR_W'(1);
                  if (bursts_left == NBUR_W'(1)) state <= DRAIN;
               end else if (!ar_vld && credit_ok) begin
                  ar_vld <= 1'b1;
               end
            end
            DRAIN: begin
               if ((words_left == '0) || ((words_left == WORD_W'(1)) && pop_vld)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
